cordic_control_fsm: RTL and testbench

- Sequencing controller directly upstream of the CORDIC coprocessor datapath.
- Generates every mux select, register-enable pulse, adder start and iteration-counter pulse the datapath needs.
- Consumes the adder `ACK_SUM`, overflow/underflow flags and the iteration address `CONT_ITERA`.
- Runs a full sin/cos evaluation and hands the result off through a start/ready/ack handshake with the host.

---
 rtl/cordic_control_fsm.sv | 215 +++++++++++++++++++++
 tb/tb_cordic_control_fsm.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/cordic_control_fsm.sv
// Sequencing controller for the CORDIC datapath: issues mux selects, register-enable
// pulses, adder starts and iteration-counter advances, then hands the result to the host.
module cordic_control_fsm #(
    parameter int D    = 5,
    parameter int ITER = 25
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         beg_FSM_CORDIC,
    input  logic         ACK_FSM_CORDIC,
    input  logic         OP_SEL,
    input  logic         ACK_SUM,
    input  logic         O_F,
    input  logic         U_F,
    input  logic [D-1:0] CONT_ITERA,
    output logic         RST_DP,
    output logic         MS_1,
    output logic [1:0]   MS_2,
    output logic [1:0]   MS_3,
    output logic [1:0]   MS_4,
    output logic         ADD_SUBT,
    output logic         Begin_SUM,
    output logic         EN_REG1X,
    output logic         EN_REG1Y,
    output logic         EN_REG1Z,
    output logic         EN_REG2,
    output logic         EN_REG2XYZ,
    output logic         EN_REG3,
    output logic         EN_REG4,
    output logic         CLK_CDIR,
    output logic         ready_CORDIC,
    output logic         error_CORDIC
);

    typedef enum logic [3:0] {
        S_IDLE, S_RESET_DP, S_LOAD_T, S_OP_SETUP, S_OP_START, S_OP_WAIT, S_OP_LATCH,
        S_SHIFT, S_SEL, S_NEXT_ITER, S_ADVANCE, S_DONE, S_ERROR
    } state_t;

    localparam logic         PH_INIT = 1'b0;
    localparam logic         PH_ITER = 1'b1;
    localparam logic [D-1:0] LAST_IT = D'(ITER - 1);
    localparam logic [1:0]   ENC_Z   = 2'd0;
    localparam logic [1:0]   ENC_Y   = 2'd1;
    localparam logic [1:0]   ENC_X   = 2'd2;

    state_t     r_state, w_state_n;
    logic [1:0] r_op, w_op_n;
    logic       r_phase, w_phase_n;
    logic       r_opsel, w_opsel_n;
    logic       w_last, w_rst_dp_n, w_ms1_n, w_add_subt_n, w_begin_n;
    logic [1:0] w_ms2_n, w_ms3_n, w_ms4_n, w_tgt;
    logic       w_en_x_n, w_en_y_n, w_en_z_n, w_en2_n, w_en2xyz_n, w_en3_n, w_en4_n;
    logic       w_cdir_n, w_ready_n, w_error_n;

    // Register bank for the datapath target of an operation (INIT: Z,X,Y; ITER: X,Y,Z)
    function automatic logic [1:0] f_target(input logic phase, input logic [1:0] op);
        logic [1:0] enc;
        if (phase == PH_ITER) begin
            enc = ENC_X - op;
        end else begin
            case (op)
                2'd0:    enc = ENC_Z;
                2'd1:    enc = ENC_X;
                default: enc = ENC_Y;
            endcase
        end
        return enc;
    endfunction

    assign w_last = (CONT_ITERA == LAST_IT);
    assign w_tgt  = f_target(w_phase_n, w_op_n);

    // Next-state logic plus next values of every registered output
    always_comb begin
        w_state_n = r_state;
        w_op_n    = r_op;
        w_phase_n = r_phase;
        w_opsel_n = r_opsel;
        case (r_state)
            S_IDLE: begin
                if (beg_FSM_CORDIC) begin
                    w_state_n = S_RESET_DP;
                    w_opsel_n = OP_SEL;
                end else begin
                    w_state_n = S_IDLE;
                end
            end
            S_RESET_DP: w_state_n = S_LOAD_T;
            S_LOAD_T: begin
                w_state_n = S_OP_SETUP;
                w_phase_n = PH_INIT;
                w_op_n    = 2'd0;
            end
            // A still-high ACK from the previous sum must clear before a new start
            S_OP_SETUP: w_state_n = ACK_SUM ? S_OP_SETUP : S_OP_START;
            S_OP_START: w_state_n = S_OP_WAIT;
            S_OP_WAIT: begin
                if (ACK_SUM) begin
                    w_state_n = (O_F || U_F) ? S_ERROR : S_OP_LATCH;
                end else begin
                    w_state_n = S_OP_WAIT;
                end
            end
            S_OP_LATCH: begin
                if (r_op == 2'd2) begin
                    w_state_n = (r_phase == PH_INIT) ? S_SHIFT : S_NEXT_ITER;
                    w_phase_n = PH_ITER;
                    w_op_n    = 2'd0;
                end else begin
                    w_state_n = (r_phase == PH_INIT) ? S_OP_SETUP : S_SEL;
                    w_op_n    = r_op + 2'd1;
                end
            end
            S_SHIFT: begin
                w_state_n = S_SEL;
                w_op_n    = 2'd0;
            end
            S_SEL:       w_state_n = S_OP_SETUP;
            S_NEXT_ITER: w_state_n = w_last ? S_DONE : S_ADVANCE;
            S_ADVANCE:   w_state_n = S_SHIFT;
            S_DONE:      w_state_n = ACK_FSM_CORDIC ? S_IDLE : S_DONE;
            S_ERROR:     w_state_n = ACK_FSM_CORDIC ? S_IDLE : S_ERROR;
            default:     w_state_n = S_IDLE;
        endcase

        w_ms1_n      = MS_1;
        w_ms2_n      = MS_2;
        w_ms3_n      = MS_3;
        w_ms4_n      = MS_4;
        w_add_subt_n = ADD_SUBT;
        if (w_state_n == S_OP_SETUP) begin
            if (w_phase_n == PH_ITER) begin
                w_ms1_n      = 1'b0;
                w_ms3_n      = w_tgt;
                w_ms4_n      = 2'd1;
                w_add_subt_n = 1'b0;
            end else begin
                w_ms1_n      = 1'b0;
                w_ms3_n      = 2'd0;
                w_ms4_n      = (w_op_n == 2'd0) ? 2'd2 : 2'd0;
                w_add_subt_n = (w_op_n != 2'd1);
            end
        end else if (w_state_n == S_SEL) begin
            w_ms2_n = w_tgt;
        end else begin
            w_ms2_n = MS_2;
        end

        w_rst_dp_n = (w_state_n == S_RESET_DP);
        w_en3_n    = (w_state_n == S_LOAD_T);
        w_begin_n  = (w_state_n == S_OP_START);
        w_en2_n    = (w_state_n == S_SHIFT);
        w_en2xyz_n = (w_state_n == S_SEL);
        w_cdir_n   = (w_state_n == S_ADVANCE);
        w_ready_n  = (w_state_n == S_DONE) || (w_state_n == S_ERROR);
        w_error_n  = (w_state_n == S_ERROR);
        w_en_x_n   = (w_state_n == S_OP_LATCH) && (w_tgt == ENC_X);
        w_en_y_n   = (w_state_n == S_OP_LATCH) && (w_tgt == ENC_Y);
        w_en_z_n   = (w_state_n == S_OP_LATCH) && (w_tgt == ENC_Z);
        // Final result leaves with the last cos (X) or sin (Y) update
        w_en4_n    = (w_state_n == S_OP_LATCH) && (w_phase_n == PH_ITER) && w_last &&
                     (w_tgt == (w_opsel_n ? ENC_Y : ENC_X));
    end

    // State, captured operation and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_op         <= 2'd0;
            r_phase      <= PH_INIT;
            r_opsel      <= 1'b0;
            RST_DP       <= 1'b0;
            MS_1         <= 1'b0;
            MS_2         <= 2'd0;
            MS_3         <= 2'd0;
            MS_4         <= 2'd0;
            ADD_SUBT     <= 1'b0;
            Begin_SUM    <= 1'b0;
            EN_REG1X     <= 1'b0;
            EN_REG1Y     <= 1'b0;
            EN_REG1Z     <= 1'b0;
            EN_REG2      <= 1'b0;
            EN_REG2XYZ   <= 1'b0;
            EN_REG3      <= 1'b0;
            EN_REG4      <= 1'b0;
            CLK_CDIR     <= 1'b0;
            ready_CORDIC <= 1'b0;
            error_CORDIC <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_op         <= w_op_n;
            r_phase      <= w_phase_n;
            r_opsel      <= w_opsel_n;
            RST_DP       <= w_rst_dp_n;
            MS_1         <= w_ms1_n;
            MS_2         <= w_ms2_n;
            MS_3         <= w_ms3_n;
            MS_4         <= w_ms4_n;
            ADD_SUBT     <= w_add_subt_n;
            Begin_SUM    <= w_begin_n;
            EN_REG1X     <= w_en_x_n;
            EN_REG1Y     <= w_en_y_n;
            EN_REG1Z     <= w_en_z_n;
            EN_REG2      <= w_en2_n;
            EN_REG2XYZ   <= w_en2xyz_n;
            EN_REG3      <= w_en3_n;
            EN_REG4      <= w_en4_n;
            CLK_CDIR     <= w_cdir_n;
            ready_CORDIC <= w_ready_n;
            error_CORDIC <= w_error_n;
        end
    end

endmodule

// File: tb/tb_cordic_control_fsm.sv
// Directed bench for cordic_control_fsm with a behavioural adder (fixed ACK latency)
// and iteration-counter model.
module tb_cordic_control_fsm;
    localparam int D   = 5;
    localparam int ITR = 25;
    localparam int LAT = 5;

    logic CLK = 1'b0;
    logic RST, beg, ackf, opsel, ACK_SUM, O_F, U_F;
    logic [D-1:0] cont;
    logic RST_DP, MS_1, ADD_SUBT, Begin_SUM, EN_REG1X, EN_REG1Y, EN_REG1Z, EN_REG2;
    logic EN_REG2XYZ, EN_REG3, EN_REG4, CLK_CDIR, ready_CORDIC, error_CORDIC;
    logic [1:0] MS_2, MS_3, MS_4;

    cordic_control_fsm #(.D(D), .ITER(ITR)) dut (
        .CLK(CLK), .RST(RST), .beg_FSM_CORDIC(beg), .ACK_FSM_CORDIC(ackf), .OP_SEL(opsel),
        .ACK_SUM(ACK_SUM), .O_F(O_F), .U_F(U_F), .CONT_ITERA(cont), .RST_DP(RST_DP),
        .MS_1(MS_1), .MS_2(MS_2), .MS_3(MS_3), .MS_4(MS_4), .ADD_SUBT(ADD_SUBT),
        .Begin_SUM(Begin_SUM), .EN_REG1X(EN_REG1X), .EN_REG1Y(EN_REG1Y), .EN_REG1Z(EN_REG1Z),
        .EN_REG2(EN_REG2), .EN_REG2XYZ(EN_REG2XYZ), .EN_REG3(EN_REG3), .EN_REG4(EN_REG4),
        .CLK_CDIR(CLK_CDIR), .ready_CORDIC(ready_CORDIC), .error_CORDIC(error_CORDIC)
    );

    always #5 CLK = ~CLK;

    int errors = 0, checks = 0, cyc = 0;
    int n_begin, n_cdir, n_x, n_y, n_z, n_reg4, n_rstdp, n_other, n_latch;
    int r4_with_x, r4_with_y, r4_xidx, r4_yidx, overlap, beg_ack;
    int t_rstdp, t_ready, t_b1, ready_seen;
    int add_cnt = 0, stuck_cnt = 0, of_idx = 0, cur_idx = 0;
    logic [9:0] prev_p = 10'd0;
    logic [7:0] sel_b [0:5];
    logic [7:0] sel_l [0:5];
    logic [7:0] exp_sel [0:5];
    bit ok;

    function automatic logic [19:0] outv();
        return {RST_DP, MS_1, MS_2, MS_3, MS_4, ADD_SUBT, Begin_SUM, EN_REG1X, EN_REG1Y,
                EN_REG1Z, EN_REG2, EN_REG2XYZ, EN_REG3, EN_REG4, CLK_CDIR, ready_CORDIC,
                error_CORDIC};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic clr();
        n_begin = 0; n_cdir = 0; n_x = 0; n_y = 0; n_z = 0; n_reg4 = 0; n_rstdp = 0;
        n_other = 0; n_latch = 0; r4_with_x = 0; r4_with_y = 0; r4_xidx = 0; r4_yidx = 0;
        overlap = 0; beg_ack = 0; t_rstdp = 0; t_ready = 0; t_b1 = 0; ready_seen = 0;
    endtask

    // One clock: sample outputs at the falling edge, then update counter and adder models
    task automatic tick();
        logic [9:0] p;
        logic [7:0] selv;
        @(negedge CLK);
        cyc++;
        p = {RST_DP, Begin_SUM, EN_REG1X, EN_REG1Y, EN_REG1Z, EN_REG2, EN_REG2XYZ,
             EN_REG3, EN_REG4, CLK_CDIR};
        if ((p & prev_p) != 10'd0) overlap++;
        prev_p = p;
        selv = {MS_1, MS_2, MS_3, MS_4, ADD_SUBT};
        if (Begin_SUM && ACK_SUM) beg_ack++;
        if (Begin_SUM) begin
            if (n_begin < 6) sel_b[n_begin] = selv;
            n_begin++;
            if (n_begin == 1) t_b1 = cyc;
        end
        if (EN_REG1X || EN_REG1Y || EN_REG1Z) begin
            if (n_latch < 6) sel_l[n_latch] = selv;
            n_latch++;
        end
        if (EN_REG1X) n_x++;
        if (EN_REG1Y) n_y++;
        if (EN_REG1Z) n_z++;
        if (EN_REG2 || EN_REG2XYZ || EN_REG3) n_other++;
        if (EN_REG4) begin
            n_reg4++; r4_with_x = EN_REG1X; r4_with_y = EN_REG1Y; r4_xidx = n_x; r4_yidx = n_y;
        end
        if (CLK_CDIR) n_cdir++;
        if (RST_DP) begin n_rstdp++; t_rstdp = cyc; end
        if (ready_CORDIC && ready_seen == 0) begin ready_seen = 1; t_ready = cyc; end
        if (RST_DP) cont = '0;
        else if (CLK_CDIR) cont = cont + 1'b1;
        ACK_SUM = 1'b0; O_F = 1'b0; U_F = 1'b0;
        if (add_cnt > 0) begin
            add_cnt--;
            if (add_cnt == 0) begin ACK_SUM = 1'b1; O_F = (cur_idx == of_idx); end
        end
        if (Begin_SUM) begin add_cnt = LAT; cur_idx = n_begin; end
        if (stuck_cnt > 0) begin ACK_SUM = 1'b1; stuck_cnt--; end
    endtask

    task automatic wait_ready(input int maxc, output bit got);
        got = 1'b0;
        for (int i = 0; i < maxc && !got; i++) begin
            tick();
            got = ready_CORDIC;
        end
    endtask

    initial begin
        RST = 1'b1; beg = 1'b0; ackf = 1'b0; opsel = 1'b0;
        ACK_SUM = 1'b0; O_F = 1'b0; U_F = 1'b0; cont = '0;
        exp_sel[0] = 8'h05; exp_sel[1] = 8'h00; exp_sel[2] = 8'h01;
        exp_sel[3] = 8'h52; exp_sel[4] = 8'h2A; exp_sel[5] = 8'h02;
        clr();
        repeat (3) tick();
        check("reset_outputs", 32'(outv()), 32'd0);
        RST = 1'b0;
        tick();

        // Run 1: cosine, 5-cycle adder
        clr(); opsel = 1'b0; beg = 1'b1;
        tick();
        beg = 1'b0;
        wait_ready(2000, ok);
        check("run1_ready_reached", 32'(ok), 32'd1);
        check("run1_total_cycles", 32'(t_ready - t_rstdp), 32'd775);
        check("run1_first_begin", 32'(t_b1 - t_rstdp), 32'd3);
        check("run1_begin_count", 32'(n_begin), 32'd78);
        check("run1_cdir_count", 32'(n_cdir), 32'd24);
        check("run1_reg4_count", 32'(n_reg4), 32'd1);
        check("run1_reg4_with_x", 32'(r4_with_x), 32'd1);
        check("run1_reg4_x_index", 32'(r4_xidx), 32'd26);
        check("run1_reg4_with_y", 32'(r4_with_y), 32'd0);
        check("run1_error_flag", 32'(error_CORDIC), 32'd0);
        check("run1_pulse_overlap", 32'(overlap), 32'd0);
        check("run1_begin_during_ack", 32'(beg_ack), 32'd0);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("run1_sel_at_begin%0d", k), 32'(sel_b[k]), 32'(exp_sel[k]));
            check($sformatf("run1_sel_at_latch%0d", k), 32'(sel_l[k]), 32'(exp_sel[k]));
        end
        repeat (3) tick();
        check("run1_ready_held", 32'(ready_CORDIC), 32'd1);
        ackf = 1'b1;
        tick();
        ackf = 1'b0;
        check("run1_ready_cleared", 32'(ready_CORDIC), 32'd0);

        // Run 2: sine, ACK stuck high into the first setup, stray start mid-run
        clr(); opsel = 1'b1; beg = 1'b1;
        tick();
        beg = 1'b0;
        check("run2_rst_dp_pulse", 32'(RST_DP), 32'd1);
        stuck_cnt = 4;
        repeat (300) tick();
        beg = 1'b1;
        tick();
        beg = 1'b0;
        wait_ready(2000, ok);
        check("run2_ready_reached", 32'(ok), 32'd1);
        check("run2_total_cycles", 32'(t_ready - t_rstdp), 32'd778);
        check("run2_first_begin_delayed", 32'(t_b1 - t_rstdp), 32'd6);
        check("run2_begin_during_ack", 32'(beg_ack), 32'd0);
        check("run2_single_start", 32'(n_rstdp), 32'd1);
        check("run2_begin_count", 32'(n_begin), 32'd78);
        check("run2_reg4_count", 32'(n_reg4), 32'd1);
        check("run2_reg4_with_y", 32'(r4_with_y), 32'd1);
        check("run2_reg4_y_index", 32'(r4_yidx), 32'd26);
        check("run2_reg4_with_x", 32'(r4_with_x), 32'd0);
        check("run2_pulse_overlap", 32'(overlap), 32'd0);

        // ACK and start together: IDLE first, new run the cycle after
        beg = 1'b1; ackf = 1'b1;
        tick();
        ackf = 1'b0;
        check("ack_beg_idle_ready", 32'(ready_CORDIC), 32'd0);
        check("ack_beg_idle_no_rstdp", 32'(RST_DP), 32'd0);
        tick();
        beg = 1'b0;
        check("ack_beg_restart_rstdp", 32'(RST_DP), 32'd1);

        // Reset during an OP_WAIT of iteration 7
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            tick();
            ok = (cont == 5'd7) && Begin_SUM;
        end
        check("iter7_reached", 32'(ok), 32'd1);
        repeat (2) tick();
        RST = 1'b1;
        tick();
        check("midrun_reset_outputs", 32'(outv()), 32'd0);
        RST = 1'b0;
        clr();
        repeat (20) tick();
        check("post_reset_no_pulses",
              32'(n_begin + n_x + n_y + n_z + n_cdir + n_rstdp + n_reg4 + n_other), 32'd0);
        check("post_reset_outputs", 32'(outv()), 32'd0);

        // Overflow on INIT op1 aborts
        clr(); of_idx = 2; opsel = 1'b0; beg = 1'b1;
        tick();
        beg = 1'b0;
        wait_ready(500, ok);
        check("err_ready_reached", 32'(ok), 32'd1);
        check("err_error_flag", 32'(error_CORDIC), 32'd1);
        check("err_no_reg1x", 32'(n_x), 32'd0);
        check("err_no_reg4", 32'(n_reg4), 32'd0);
        check("err_begin_count", 32'(n_begin), 32'd2);
        check("err_reg1z_count", 32'(n_z), 32'd1);
        of_idx = 0;
        ackf = 1'b1;
        tick();
        ackf = 1'b0;
        check("err_flags_cleared", 32'({ready_CORDIC, error_CORDIC}), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
